count_sequencer: RTL



---
 rtl/count_sequencer.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/count_sequencer.sv
// count_sequencer
//   Programmable timer controller. Latches a period P and a run mode at start,
//   then steps an internal counter 0..P-1. Reports terminal counts with
//   one-cycle pulses. Runs are one-shot or periodic. Optional prescaler is
//   enabled with the COUNT_SEQ_PRESCALE_EN macro.
//
// Parameters
//   WIDTH       width of period and count
//   PRESCALE_W  prescaler width (only used with COUNT_SEQ_PRESCALE_EN)
//
// Ports
//   clk       clock, all state updates on posedge
//   reset     asynchronous active-high reset
//   start     request a run; sampled only while idle
//   stop      abort the current run (wins over hold and terminal)
//   hold      freeze counting while high
//   mode      0 = one-shot, 1 = periodic; latched at start
//   period    terminal count P; latched at start; 0 is rejected with err
//   prescale  divider value (COUNT_SEQ_PRESCALE_EN only); latched at start
//   count     current count value
//   busy      high while running or paused
//   tick      one-cycle pulse on each terminal count
//   done      one-cycle pulse at the end of a one-shot run
//   err       one-cycle pulse when start is rejected
module count_sequencer #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             hold,
  input  logic             mode,
  input  logic [WIDTH-1:0] period,
`ifdef COUNT_SEQ_PRESCALE_EN
  input  logic [PRESCALE_W-1:0] prescale,
`endif
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             tick,
  output logic             done,
  output logic             err
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] PAUSE = 2'd2;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] period_reg;
  logic             mode_reg;
  logic             busy_reg;
  logic             tick_reg;
  logic             done_reg;
  logic             err_reg;

  // Terminal value; period_reg is never 0 while running, so no wrap occurs.
  logic [WIDTH-1:0] last_count;
  assign last_count = period_reg - 1'b1;

  // advance: this RUN edge is allowed to step the counter / evaluate terminal.
`ifdef COUNT_SEQ_PRESCALE_EN
  logic [PRESCALE_W-1:0] prescale_reg;
  logic [PRESCALE_W-1:0] div_reg;
  logic                  advance;
  assign advance = (div_reg == prescale_reg);
`else
  logic advance;
  assign advance = 1'b1;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= IDLE;
      count_reg  <= '0;
      period_reg <= '0;
      mode_reg   <= 1'b0;
      busy_reg   <= 1'b0;
      tick_reg   <= 1'b0;
      done_reg   <= 1'b0;
      err_reg    <= 1'b0;
`ifdef COUNT_SEQ_PRESCALE_EN
      prescale_reg <= '0;
      div_reg      <= '0;
`endif
    end else begin
      // Pulses default low every edge.
      tick_reg <= 1'b0;
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            if (period != '0) begin
              period_reg <= period;
              mode_reg   <= mode;
              count_reg  <= '0;
              busy_reg   <= 1'b1;
              state_reg  <= RUN;
`ifdef COUNT_SEQ_PRESCALE_EN
              prescale_reg <= prescale;
              div_reg      <= '0;
`endif
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        RUN: begin
          if (stop) begin
            // Abort: count holds its last value, no pulses.
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
`ifdef COUNT_SEQ_PRESCALE_EN
            div_reg   <= '0;
`endif
          end else if (hold) begin
            state_reg <= PAUSE;
          end else begin
`ifdef COUNT_SEQ_PRESCALE_EN
            div_reg <= advance ? '0 : div_reg + 1'b1;
`endif
            if (advance) begin
              if (count_reg == last_count) begin
                tick_reg <= 1'b1;
                if (mode_reg) begin
                  count_reg <= '0;
                end else begin
                  // One-shot: count stays at P-1 and busy drops with done.
                  done_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
                  state_reg <= IDLE;
                end
              end else begin
                count_reg <= count_reg + 1'b1;
              end
            end
          end
        end
        PAUSE: begin
          if (stop) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
`ifdef COUNT_SEQ_PRESCALE_EN
            div_reg   <= '0;
`endif
          end else if (!hold) begin
            // Resume edge does not count.
            state_reg <= RUN;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign count = count_reg;
  assign busy  = busy_reg;
  assign tick  = tick_reg;
  assign done  = done_reg;
  assign err   = err_reg;

endmodule
